// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared state encoding and decode helpers for the instruction sequencer
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

  // Every RV32 base-length instruction carries 2'b11 in its lowest opcode bits
  localparam logic [1:0] OPC_LOW = 2'b11;

  // Legal means a 32-bit encoding, and not the all-zero word when that is treated as a halt
  function automatic logic ins_is_legal(input logic [31:0] ins, input logic halt_on_zero);
    logic w_zero;
    w_zero = (ins == 32'h0);
    return (ins[1:0] == OPC_LOW) && !(halt_on_zero && w_zero);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - EXEC-phase wait timer with terminal-count flag
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;

  // Count waiting cycles; hold at terminal value so the flag stays asserted until cleared
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_tc) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - FETCH/DECODE/EXEC/WB sequencer gating PC, register write and ALU handshake
module exec_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int CNT_W            = 32,
  parameter int HALT_ON_ZERO_INS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [31:0]      i_ins,
  input  logic             i_ctrl_regwen,
  input  logic             i_alu_multicycle,
  input  logic             i_alu_ready,
  output logic             o_ins_latch,
  output logic             o_alu_start,
  output logic             o_reg_we,
  output logic             o_pc_en,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_err_timeout,
  output logic [CNT_W-1:0] o_retired_count
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic             w_legal;
  logic             w_in_exec;
  logic             w_wait_alu;
  logic             w_timer_clear;
  logic             w_timer_en;
  logic             w_timer_tc;
  logic             w_timeout;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_retired_count;

  assign w_legal    = ins_is_legal(i_ins, HALT_ON_ZERO_INS != 0);
  assign w_in_exec  = (r_state == EXEC);
  // Still waiting on a multicycle ALU result this cycle
  assign w_wait_alu = w_in_exec && i_alu_multicycle && !i_alu_ready;
  // A ready arriving on the terminal cycle still wins over the timeout
  assign w_timeout  = w_wait_alu && w_timer_tc;

  // Timer restarts in DECODE so the first EXEC cycle sees a count of zero
  assign w_timer_clear = (r_state == DECODE);
  assign w_timer_en    = w_wait_alu;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_tc     (w_timer_tc)
  );

  // Next-state selection; run is only looked at on instruction boundaries
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   w_next_state = i_run ? FETCH : IDLE;
      FETCH:  w_next_state = DECODE;
      DECODE: w_next_state = w_legal ? EXEC : HALT;
      EXEC: begin
        if (!i_alu_multicycle || i_alu_ready) begin
          w_next_state = WB;
        end else if (w_timer_tc) begin
          w_next_state = HALT;
        end else begin
          w_next_state = EXEC;
        end
      end
      WB:     w_next_state = i_run ? FETCH : IDLE;
      HALT:   w_next_state = HALT;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Retired-instruction count advances once per writeback and wraps silently
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_retired_count <= '0;
    end else if (r_state == WB) begin
      r_retired_count <= r_retired_count + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign o_ins_latch     = (r_state == FETCH);
  assign o_alu_start     = (r_state == DECODE) && w_legal;
  assign o_reg_we        = (r_state == WB) && i_ctrl_regwen;
  assign o_pc_en         = (r_state == WB);
  assign o_busy          = (r_state == FETCH) || (r_state == DECODE) ||
                           (r_state == EXEC)  || (r_state == WB);
  assign o_halted        = (r_state == HALT);
  assign o_err_timeout   = r_err_timeout;
  assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer
module tb_exec_sequencer;

  localparam int TO   = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [31:0]   ins = 32'h0;
  logic          regwen = 1'b0;
  logic          multi = 1'b0;
  logic          ready = 1'b0;
  logic          ins_latch, alu_start, reg_we, pc_en, busy, halted, err_timeout;
  logic [CW-1:0] retired_count;

  int n_cmp = 0;
  int n_bad = 0;

  exec_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW),
    .HALT_ON_ZERO_INS(1)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_run           (run),
    .i_ins           (ins),
    .i_ctrl_regwen   (regwen),
    .i_alu_multicycle(multi),
    .i_alu_ready     (ready),
    .o_ins_latch     (ins_latch),
    .o_alu_start     (alu_start),
    .o_reg_we        (reg_we),
    .o_pc_en         (pc_en),
    .o_busy          (busy),
    .o_halted        (halted),
    .o_err_timeout   (err_timeout),
    .o_retired_count (retired_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] MUL = 32'h022081B3;

  typedef struct {
    logic [31:0] ins;
    logic        rw;
    logic        mc;
    int          d;       // window offset of the ready pulse: EXEC cycle d (0 = DECODE cycle)
    int          e_busy;
    int          e_start;
    int          e_we;
    int          e_pc;
    int          e_halt;
    int          e_err;
    int          e_ret;
  } vec_t;

  vec_t vecs[8];

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // flags are {ins_latch, alu_start, reg_we, pc_en, busy, halted, err_timeout}
  task automatic drive_check(input logic run_v, input logic [31:0] ins_v, input logic rw_v,
                             input logic mc_v, input logic rdy_v, input logic [6:0] e_flg,
                             input logic [CW-1:0] e_ret, input string tag);
    logic [6:0] a_flg;
    @(negedge clk);
    run = run_v; ins = ins_v; regwen = rw_v; multi = mc_v; ready = rdy_v;
    #1;
    a_flg = {ins_latch, alu_start, reg_we, pc_en, busy, halted, err_timeout};
    n_cmp++;
    if (a_flg !== e_flg || retired_count !== e_ret) begin
      n_bad++;
      $display("FAIL %s: flags=%b ret=%0d expected flags=%b ret=%0d",
               tag, a_flg, retired_count, e_flg, e_ret);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy, n_start, n_we, n_pc, n_latch;
    logic done;
    logic [CW-1:0] ret;
    logic [31:0] i_v;
    logic legal, rw, mc, halted_m, err_m;
    int kind, d, ex_len;

    vecs[0] = '{ADD,   1'b1, 1'b0, 0, 4,  1, 1, 1, 0, 0, 1};
    vecs[1] = '{ADD,   1'b0, 1'b0, 0, 4,  1, 0, 1, 0, 0, 1};
    vecs[2] = '{MUL,   1'b1, 1'b1, 5, 8,  1, 1, 1, 0, 0, 1};
    vecs[3] = '{MUL,   1'b1, 1'b1, 1, 4,  1, 1, 1, 0, 0, 1};
    vecs[4] = '{MUL,   1'b1, 1'b1, 8, 11, 1, 1, 1, 0, 0, 1};
    vecs[5] = '{MUL,   1'b1, 1'b1, 0, 10, 1, 0, 0, 1, 1, 0};
    vecs[6] = '{32'h0, 1'b1, 1'b0, 0, 2,  0, 0, 0, 1, 0, 0};
    vecs[7] = '{32'h00208181, 1'b1, 1'b0, 0, 2, 0, 0, 0, 1, 0, 0};

    // Reset state
    do_reset();
    drive_check(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'b0, 4'd0, "reset state");

    // Table: one instruction from reset, run only raised for the first IDLE cycle
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n_busy = 0; n_start = 0; n_we = 0; n_pc = 0; n_latch = 0; done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        @(negedge clk);
        run = (k == 0); ins = vecs[r].ins; regwen = vecs[r].rw; multi = vecs[r].mc;
        ready = (k == 2 + vecs[r].d);
        #1;
        if (busy) n_busy++;
        if (alu_start) n_start++;
        if (reg_we) n_we++;
        if (pc_en) n_pc++;
        if (ins_latch) n_latch++;
        if (k > 0 && !busy) done = 1'b1;
      end
      chk($sformatf("row%0d done", r), int'(done), 1);
      chk($sformatf("row%0d busy_cycles", r), n_busy, vecs[r].e_busy);
      chk($sformatf("row%0d ins_latch", r), n_latch, 1);
      chk($sformatf("row%0d alu_start", r), n_start, vecs[r].e_start);
      chk($sformatf("row%0d reg_we", r), n_we, vecs[r].e_we);
      chk($sformatf("row%0d pc_en", r), n_pc, vecs[r].e_pc);
      chk($sformatf("row%0d halted", r), int'(halted), vecs[r].e_halt);
      chk($sformatf("row%0d err_timeout", r), int'(err_timeout), vecs[r].e_err);
      chk($sformatf("row%0d retired", r), int'(retired_count), vecs[r].e_ret);
    end

    // Three adds back to back, run dropped during EXEC of the third
    do_reset();
    drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b0000000, 4'd0, "seq5 idle");
    for (int k = 0; k < 3; k++) begin
      drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b1000100, 4'(k), "seq5 fetch");
      drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b0100100, 4'(k), "seq5 decode");
      drive_check(k < 2, ADD, 1'b1, 1'b0, 1'b1, 7'b0000100, 4'(k), "seq5 exec");
      drive_check(k < 2, ADD, 1'b1, 1'b0, 1'b0, 7'b0011100, 4'(k), "seq5 wb");
    end
    drive_check(1'b0, ADD, 1'b1, 1'b0, 1'b0, 7'b0, 4'd3, "seq5 idle after");
    drive_check(1'b0, ADD, 1'b1, 1'b0, 1'b0, 7'b0, 4'd3, "seq5 idle hold");

    // Reset on the second EXEC cycle of a multicycle op
    do_reset();
    drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b0000000, 4'd0, "seq6 idle");
    drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b1000100, 4'd0, "seq6 add fetch");
    drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b0100100, 4'd0, "seq6 add decode");
    drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b0000100, 4'd0, "seq6 add exec");
    drive_check(1'b1, ADD, 1'b1, 1'b0, 1'b0, 7'b0011100, 4'd0, "seq6 add wb");
    drive_check(1'b1, MUL, 1'b1, 1'b1, 1'b0, 7'b1000100, 4'd1, "seq6 mul fetch");
    drive_check(1'b1, MUL, 1'b1, 1'b1, 1'b0, 7'b0100100, 4'd1, "seq6 mul decode");
    drive_check(1'b1, MUL, 1'b1, 1'b1, 1'b0, 7'b0000100, 4'd1, "seq6 mul exec1");
    drive_check(1'b1, MUL, 1'b1, 1'b1, 1'b0, 7'b0000100, 4'd1, "seq6 mul exec2");
    rst = 1'b1;
    drive_check(1'b0, MUL, 1'b1, 1'b1, 1'b1, 7'b0, 4'd0, "seq6 after rst");
    rst = 1'b0;
    drive_check(1'b0, MUL, 1'b1, 1'b1, 1'b1, 7'b0, 4'd0, "seq6 idle after rst");

    // Randomised programs against a schedule-level model
    for (int p = 0; p < 25; p++) begin
      do_reset();
      ret = '0;
      halted_m = 1'b0;
      err_m = 1'b0;
      drive_check(1'b1, 32'h13, 1'b0, 1'b0, rbit(), 7'b0, ret, "rnd idle");
      for (int n = 0; n < 12 && !halted_m; n++) begin
        kind = $urandom_range(0, 19);
        if (kind == 0) i_v = 32'h0;
        else if (kind == 1) i_v = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 2));
        else i_v = $urandom | 32'h3;
        legal = (i_v[1:0] == 2'b11);
        rw = rbit();
        mc = rbit();
        d = $urandom_range(1, TO + 1);
        ex_len = !mc ? 1 : ((d <= TO) ? d : TO);
        drive_check(rbit(), i_v, rw, mc, rbit(), 7'b1000100, ret, "rnd fetch");
        drive_check(rbit(), i_v, rw, mc, rbit(), {1'b0, legal, 5'b00100}, ret, "rnd decode");
        if (!legal) begin
          halted_m = 1'b1;
        end else begin
          for (int j = 1; j <= ex_len; j++)
            drive_check(rbit(), i_v, rw, mc, mc ? (j == d) : rbit(), 7'b0000100, ret, "rnd exec");
          if (mc && d > TO) begin
            halted_m = 1'b1;
            err_m = 1'b1;
          end else begin
            drive_check(n != 11, i_v, rw, mc, rbit(), {2'b00, rw, 4'b1100}, ret, "rnd wb");
            ret = ret + 4'd1;
          end
        end
      end
      if (halted_m) begin
        for (int h = 0; h < 3; h++)
          drive_check(rbit(), 32'h13, rbit(), rbit(), rbit(), {5'b00000, 1'b1, err_m}, ret, "rnd halt");
      end else begin
        drive_check(1'b0, 32'h13, 1'b0, 1'b0, rbit(), 7'b0, ret, "rnd idle end");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
